// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the arbiter state encoding and the datapath word width.
package mem_arb_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: data port has fixed priority over fetch.
// One backend access outstanding at most; done pulses are registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic [WORD_W-1:0] i_data,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_stall,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              err
);

    state_e state_q, state_d;

    logic              wr_q;
    logic              i_done_q;
    logic              d_done_q;
    logic [WORD_W-1:0] i_data_q;
    logic [WORD_W-1:0] d_rdata_q;
    logic              err_q;

    logic d_req;
    logic i_go;
    logic idle;
    logic issue_d;
    logic issue_i;
    logic d_fin;
    logic i_fin;
    logic bad_align;

    // A client in its done cycle still holds its request; mask it so the
    // access is not re-issued and the other client can go on that cycle.
    always_comb begin
        d_req     = (d_rd | d_wr) & ~d_done_q;
        i_go      = i_req & ~i_done_q & ~halt;
        idle      = (state_q == IDLE);
        issue_d   = idle & d_req & ~mem_stall & ~rst;
        issue_i   = idle & ~d_req & i_go & ~mem_stall & ~rst;
        d_fin     = (state_q == D_BUSY) & mem_done;
        i_fin     = (state_q == I_BUSY) & mem_done;
        bad_align = ALIGN_CHECK &
                    ((issue_d & d_addr[0]) | (issue_i & i_addr[0]));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; busy states wait only for the backend completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue_d) begin
                    state_d = D_BUSY;
                end else if (issue_i) begin
                    state_d = I_BUSY;
                end
            end
            D_BUSY: begin
                if (mem_done) begin
                    state_d = IDLE;
                end
            end
            I_BUSY: begin
                if (mem_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Backend command decode; a read+write data request is issued as a write
    always_comb begin
        mem_rd    = issue_i | (issue_d & ~d_wr);
        mem_wr    = issue_d & d_wr;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue_d) begin
            mem_addr = d_addr;
            if (d_wr) begin
                mem_wdata = d_wdata;
            end
        end else if (issue_i) begin
            mem_addr = i_addr;
        end
    end

    // Completion pulses, captured data and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (issue_d) begin
                wr_q <= d_wr;
            end
            i_done_q <= i_fin;
            d_done_q <= d_fin;
            if (i_fin) begin
                i_data_q <= mem_rdata;
            end
            if (d_fin && !wr_q) begin
                d_rdata_q <= mem_rdata;
            end
            if ((issue_d & d_rd & d_wr) | bad_align) begin
                err_q <= 1'b1;
            end
        end
    end

    // Client-facing status
    always_comb begin
        i_done  = i_done_q;
        d_done  = d_done_q;
        i_data  = i_data_q;
        d_rdata = d_rdata_q;
        err     = err_q;
        i_stall = i_req & ~i_done_q;
        d_stall = (d_rd | d_wr) & ~d_done_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-by-cycle bench for mem_arbiter.
// Each table row is one clock: inputs driven after posedge, outputs sampled at negedge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, halt, i_req, d_rd, d_wr, mem_stall, mem_done;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [15:0] i_data, d_rdata, mem_addr, mem_wdata;
    logic        i_done, i_stall, d_done, d_stall, mem_rd, mem_wr, err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data),
        .i_done(i_done), .i_stall(i_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_stall(mem_stall),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
    );

    typedef struct {
        logic        rst, halt, ireq;
        logic [15:0] ia;
        logic        drd, dwr;
        logic [15:0] da, dw;
        logic        mst, mdn;
        logic [15:0] mrd_data;
        logic        e_rd, e_wr;
        logic [15:0] e_addr, e_wdata;
        logic        e_idone, e_ddone, e_istall, e_dstall, e_err;
        logic [15:0] e_idata, e_drdata;
    } vec_t;

    localparam int NV = 40;
    vec_t v[NV];

    task automatic drive(input vec_t x);
        rst = x.rst; halt = x.halt; i_req = x.ireq; i_addr = x.ia;
        d_rd = x.drd; d_wr = x.dwr; d_addr = x.da; d_wdata = x.dw;
        mem_stall = x.mst; mem_done = x.mdn; mem_rdata = x.mrd_data;
    endtask

    task automatic check(input string nm, input vec_t x);
        logic [70:0] got, exp;
        got = {mem_rd, mem_wr, mem_addr, mem_wdata, i_done, d_done,
               i_stall, d_stall, err, i_data, d_rdata};
        exp = {x.e_rd, x.e_wr, x.e_addr, x.e_wdata, x.e_idone, x.e_ddone,
               x.e_istall, x.e_dstall, x.e_err, x.e_idata, x.e_drdata};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got rd,wr,addr,wdata,idone,ddone,istall,dstall,err,idata,drdata=%h required %h",
                     nm, got, exp);
        end
    endtask

    initial begin
        vec_t h;
        // rst hlt ireq ia       drd dwr da       dw       mst mdn mrdata  | rd wr addr     wdata    idn ddn ist dst err idata    drdata
        v[0]  = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,0,16'h0000,16'h0000};
        // fetch only
        v[1]  = '{0,0,1,16'h0010,0,0,16'h0000,16'h0000,0,0,16'h0000, 1,0,16'h0010,16'h0000,0,0,1,0,0,16'h0000,16'h0000};
        v[2]  = '{0,0,1,16'h0010,0,0,16'h0000,16'h0000,0,1,16'h1234, 0,0,16'h0000,16'h0000,0,0,1,0,0,16'h0000,16'h0000};
        v[3]  = '{0,0,1,16'h0010,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,1,0,0,0,0,16'h1234,16'h0000};
        v[4]  = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,0,16'h1234,16'h0000};
        // simultaneous: data first, fetch on d_done cycle
        v[5]  = '{0,0,1,16'h0020,1,0,16'h0100,16'h0000,0,0,16'h0000, 1,0,16'h0100,16'h0000,0,0,1,1,0,16'h1234,16'h0000};
        v[6]  = '{0,0,1,16'h0020,1,0,16'h0100,16'h0000,0,1,16'h5678, 0,0,16'h0000,16'h0000,0,0,1,1,0,16'h1234,16'h0000};
        v[7]  = '{0,0,1,16'h0020,1,0,16'h0100,16'h0000,0,0,16'h0000, 1,0,16'h0020,16'h0000,0,1,1,0,0,16'h1234,16'h5678};
        v[8]  = '{0,0,1,16'h0020,0,0,16'h0000,16'h0000,0,1,16'h9ABC, 0,0,16'h0000,16'h0000,0,0,1,0,0,16'h1234,16'h5678};
        v[9]  = '{0,0,1,16'h0020,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,1,0,0,0,0,16'h9ABC,16'h5678};
        v[10] = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,0,16'h9ABC,16'h5678};
        // store
        v[11] = '{0,0,0,16'h0000,0,1,16'h0040,16'hBEEF,0,0,16'h0000, 0,1,16'h0040,16'hBEEF,0,0,0,1,0,16'h9ABC,16'h5678};
        v[12] = '{0,0,0,16'h0000,0,1,16'h0040,16'hBEEF,0,1,16'h1111, 0,0,16'h0000,16'h0000,0,0,0,1,0,16'h9ABC,16'h5678};
        v[13] = '{0,0,0,16'h0000,0,1,16'h0040,16'hBEEF,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,1,0,0,0,16'h9ABC,16'h5678};
        v[14] = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,0,16'h9ABC,16'h5678};
        // backend busy for 3 cycles
        v[15] = '{0,0,1,16'h0030,0,0,16'h0000,16'h0000,1,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,1,0,0,16'h9ABC,16'h5678};
        v[16] = '{0,0,1,16'h0030,0,0,16'h0000,16'h0000,1,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,1,0,0,16'h9ABC,16'h5678};
        v[17] = '{0,0,1,16'h0030,0,0,16'h0000,16'h0000,1,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,1,0,0,16'h9ABC,16'h5678};
        v[18] = '{0,0,1,16'h0030,0,0,16'h0000,16'h0000,0,0,16'h0000, 1,0,16'h0030,16'h0000,0,0,1,0,0,16'h9ABC,16'h5678};
        v[19] = '{0,0,1,16'h0030,0,0,16'h0000,16'h0000,0,1,16'h0042, 0,0,16'h0000,16'h0000,0,0,1,0,0,16'h9ABC,16'h5678};
        v[20] = '{0,0,1,16'h0030,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,1,0,0,0,0,16'h0042,16'h5678};
        v[21] = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,0,16'h0042,16'h5678};
        // misaligned load sets sticky err
        v[22] = '{0,0,0,16'h0000,1,0,16'h0003,16'h0000,0,0,16'h0000, 1,0,16'h0003,16'h0000,0,0,0,1,0,16'h0042,16'h5678};
        v[23] = '{0,0,0,16'h0000,1,0,16'h0003,16'h0000,0,1,16'h7777, 0,0,16'h0000,16'h0000,0,0,0,1,1,16'h0042,16'h5678};
        v[24] = '{0,0,0,16'h0000,1,0,16'h0003,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,1,0,0,1,16'h0042,16'h7777};
        // halt blocks fetch; stray mem_done in IDLE ignored
        v[25] = '{0,1,1,16'h0040,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,1,0,1,16'h0042,16'h7777};
        v[26] = '{0,1,1,16'h0040,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,1,0,1,16'h0042,16'h7777};
        v[27] = '{0,1,0,16'h0000,0,0,16'h0000,16'h0000,0,1,16'hAAAA, 0,0,16'h0000,16'h0000,0,0,0,0,1,16'h0042,16'h7777};
        v[28] = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,1,16'h0042,16'h7777};
        // reset clears err and data
        v[29] = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,1,16'h0042,16'h7777};
        v[30] = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,0,16'h0000,16'h0000};
        // rd+wr together: treated as write, err set, d_rdata untouched
        v[31] = '{0,0,0,16'h0000,1,1,16'h0044,16'hCAFE,0,0,16'h0000, 0,1,16'h0044,16'hCAFE,0,0,0,1,0,16'h0000,16'h0000};
        v[32] = '{0,0,0,16'h0000,1,1,16'h0044,16'hCAFE,0,1,16'h3333, 0,0,16'h0000,16'h0000,0,0,0,1,1,16'h0000,16'h0000};
        v[33] = '{0,0,0,16'h0000,1,1,16'h0044,16'hCAFE,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,1,0,0,1,16'h0000,16'h0000};
        v[34] = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,1,16'h0000,16'h0000};
        // reset in I_BUSY abandons the access
        v[35] = '{1,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,1,16'h0000,16'h0000};
        v[36] = '{0,0,1,16'h0050,0,0,16'h0000,16'h0000,0,0,16'h0000, 1,0,16'h0050,16'h0000,0,0,1,0,0,16'h0000,16'h0000};
        v[37] = '{1,0,1,16'h0050,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,1,0,0,16'h0000,16'h0000};
        v[38] = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,1,16'hDEAD, 0,0,16'h0000,16'h0000,0,0,0,0,0,16'h0000,16'h0000};
        v[39] = '{0,0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,16'h0000,16'h0000,0,0,0,0,0,16'h0000,16'h0000};

        drive(v[0]);
        repeat (2) @(posedge clk);

        for (int k = 0; k < NV; k++) begin
            #1;
            drive(v[k]);
            @(negedge clk);
            check($sformatf("vec%0d", k), v[k]);
            @(posedge clk);
        end

        // misaligned fetch: access proceeds, err rises after issue
        h = v[39];
        h.ireq = 1; h.ia = 16'h0061;
        h.e_rd = 1; h.e_addr = 16'h0061; h.e_istall = 1;
        #1; drive(h); @(negedge clk); check("misfetch_issue", h);
        @(posedge clk);
        h.mdn = 1; h.mrd_data = 16'h0BAD;
        h.e_rd = 0; h.e_addr = 16'h0000; h.e_err = 1;
        #1; drive(h); @(negedge clk); check("misfetch_busy", h);
        @(posedge clk);
        h.mdn = 0; h.mrd_data = 16'h0000;
        h.e_idone = 1; h.e_istall = 0; h.e_idata = 16'h0BAD;
        #1; drive(h); @(negedge clk); check("misfetch_done", h);
        @(posedge clk);
        h.ireq = 0; h.ia = 16'h0000; h.e_idone = 0;
        #1; drive(h); @(negedge clk); check("misfetch_after", h);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
